// File: rtl/asym_pipe_mult.sv
// ---------------------------------------------------------------------------
// asym_pipe_mult -- pipelined asymmetric split multiplier with valid/ready.
//
// Each operand is split into a high part (WIDTH-SPLIT bits) and a low part
// (SPLIT bits). The four sub-products are registered, then recombined with
// the proper shifts. approx_mode drops the low x low term, which bounds the
// error to (2^SPLIT-1)^2 and never overshoots the exact product.
//
// Pipeline: S1 operand capture -> S2 sub-products -> S3 recombination.
// All stages advance together (global stall), so bubbles are kept as-is.
//
// Parameters:
//   WIDTH  operand width, 2..32
//   SPLIT  low-part width, 1..WIDTH-1
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   in_valid/in_ready/a/b/approx_mode   operand stream (in_ready combinational)
//   out_valid/out_ready/p               product stream, p is 2*WIDTH bits
//   txn_count      saturating accepted-transaction counter
//
// Build option: define ASYM_PIPE_MULT_STATS_EN to enable txn_count;
// otherwise the port is tied to zero and no counter exists.
// ---------------------------------------------------------------------------

// One sub-product term with an optional force-to-zero (used for approx mode).
module apm_subprod #(
  parameter int AW = 4,
  parameter int BW = 4,
  parameter int PW = AW + BW
) (
  input  logic [AW-1:0] i_x,
  input  logic [BW-1:0] i_y,
  input  logic          i_zero,
  output logic [PW-1:0] o_p
);
  assign o_p = i_zero ? '0 : PW'(i_x) * PW'(i_y);
endmodule

module asym_pipe_mult #(
  parameter int WIDTH = 8,
  parameter int SPLIT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic [15:0]        txn_count
);
  localparam int L      = SPLIT;
  localparam int H      = WIDTH - SPLIT;
  localparam int PW     = 2 * WIDTH + 1;
  localparam int STAGES = 3;

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("asym_pipe_mult: WIDTH=%0d outside 2..32", WIDTH);
  end
  if (SPLIT < 1 || SPLIT > WIDTH - 1) begin : g_bad_split
    $error("asym_pipe_mult: SPLIT=%0d outside 1..WIDTH-1", SPLIT);
  end

  // Stage valid bits; bit STAGES is the output valid.
  logic [STAGES:1] r_vld_pipe;
  logic            w_adv;

  assign out_valid = r_vld_pipe[STAGES];
  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;

  // ---- stage 1: operand capture ----
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_apx;

  // ---- stage 2: sub-products ----
  logic [H-1:0]   w_ah, w_bh;
  logic [L-1:0]   w_al, w_bl;
  logic [2*L-1:0] w_pll, r_pll;
  logic [H+L-1:0] w_phl, r_phl;
  logic [H+L-1:0] w_plh, r_plh;
  logic [2*H-1:0] w_phh, r_phh;

  assign w_ah = r_a[WIDTH-1:L];
  assign w_al = r_a[L-1:0];
  assign w_bh = r_b[WIDTH-1:L];
  assign w_bl = r_b[L-1:0];

  apm_subprod #(.AW(L), .BW(L)) u_pll (.i_x(w_al), .i_y(w_bl), .i_zero(r_apx), .o_p(w_pll));
  apm_subprod #(.AW(H), .BW(L)) u_phl (.i_x(w_ah), .i_y(w_bl), .i_zero(1'b0),  .o_p(w_phl));
  apm_subprod #(.AW(L), .BW(H)) u_plh (.i_x(w_al), .i_y(w_bh), .i_zero(1'b0),  .o_p(w_plh));
  apm_subprod #(.AW(H), .BW(H)) u_phh (.i_x(w_ah), .i_y(w_bh), .i_zero(1'b0),  .o_p(w_phh));

  // ---- stage 3: recombination ----
  // One extra bit covers the cross-term sum; the true product always fits
  // in 2*WIDTH bits so the top bit is dropped.
  logic [PW-1:0]      w_sum;
  logic               w_unused_msb;
  logic [2*WIDTH-1:0] r_p;

  assign w_sum = (PW'(r_phh) << (2 * L))
               + ((PW'(r_phl) + PW'(r_plh)) << L)
               + PW'(r_pll);
  assign w_unused_msb = w_sum[PW-1];
  assign p = r_p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_apx      <= 1'b0;
      r_pll      <= '0;
      r_phl      <= '0;
      r_plh      <= '0;
      r_phh      <= '0;
      r_p        <= '0;
    end else if (w_adv) begin
      // A bubble (in_valid=0) is captured like any other slot.
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
      r_a        <= a;
      r_b        <= b;
      r_apx      <= approx_mode;
      r_pll      <= w_pll;
      r_phl      <= w_phl;
      r_plh      <= w_plh;
      r_phh      <= w_phh;
      r_p        <= w_sum[2*WIDTH-1:0];
    end
  end

`ifdef ASYM_PIPE_MULT_STATS_EN
  logic [15:0] r_txn;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_txn <= '0;
    end else if (in_valid && w_adv && (r_txn != 16'hFFFF)) begin
      r_txn <= r_txn + 16'd1;
    end
  end

  assign txn_count = r_txn;
`else
  assign txn_count = 16'd0;
`endif

endmodule

// File: tb/tb_asym_pipe_mult.sv
module tb_asym_pipe_mult;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef ASYM_PIPE_MULT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // inst 0: WIDTH=8 SPLIT=3 ; inst 1: WIDTH=16 SPLIT=5 ; inst 2: WIDTH=8 SPLIT=1
  logic        iv0, ir0, ap0, ov0, or0;
  logic [7:0]  a0, b0;
  logic [15:0] p0, tc0;
  logic        iv1, ir1, ap1, ov1, or1;
  logic [15:0] a1, b1;
  logic [31:0] p1;
  logic [15:0] tc1;
  logic        iv2, ir2, ap2, ov2, or2;
  logic [7:0]  a2, b2;
  logic [15:0] p2, tc2;

  asym_pipe_mult #(.WIDTH(8), .SPLIT(3)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .approx_mode(ap0), .out_valid(ov0), .out_ready(or0), .p(p0), .txn_count(tc0));
  asym_pipe_mult #(.WIDTH(16), .SPLIT(5)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .approx_mode(ap1), .out_valid(ov1), .out_ready(or1), .p(p1), .txn_count(tc1));
  asym_pipe_mult #(.WIDTH(8), .SPLIT(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .approx_mode(ap2), .out_valid(ov2), .out_ready(or2), .p(p2), .txn_count(tc2));

  int n_tests = 0;
  int n_fail  = 0;

  longint unsigned sq [3][$];
  int              cnt [3];
  bit              pstall [3];
  longint unsigned pprev [3];

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: exact product, minus the low x low term in approx mode.
  function automatic longint unsigned model(input longint unsigned x, input longint unsigned y,
                                            input bit apx, input int split);
    longint unsigned m;
    m = (64'd1 << split) - 64'd1;
    return x * y - (apx ? (x & m) * (y & m) : 64'd0);
  endfunction

  // Scoreboard for one instance, evaluated on the falling edge with the
  // values that the next rising edge will act on.
  task automatic scb(input int i, input string nm, input bit iv, input bit ir, input bit ov,
                     input bit ordy, input longint unsigned x, input longint unsigned y,
                     input bit apx, input longint unsigned pv, input longint unsigned tc,
                     input int split);
    if (!rst_n) begin
      sq[i].delete();
      cnt[i]    = 0;
      pstall[i] = 1'b0;
      return;
    end
    chk({nm, " in_ready"}, ir, (!ov || ordy));
    if (pstall[i]) begin
      chk({nm, " hold_valid"}, ov, 1);
      chk({nm, " hold_p"}, pv, pprev[i]);
    end
    chk({nm, " txn_count"}, tc, STATS ? longint'(cnt[i]) : 64'd0);
    if (ov && ordy) begin
      if (sq[i].size() == 0) chk({nm, " unexpected_out"}, sq[i].size(), 1);
      else chk({nm, " p"}, pv, sq[i].pop_front());
    end
    if (iv && ir) begin
      sq[i].push_back(model(x, y, apx, split));
      if (cnt[i] < 65535) cnt[i]++;
    end
    pstall[i] = ov && !ordy;
    pprev[i]  = pv;
  endtask

  always @(negedge clk) begin
    scb(0, "w8s3",  iv0, ir0, ov0, or0, a0, b0, ap0, p0, tc0, 3);
    scb(1, "w16s5", iv1, ir1, ov1, or1, a1, b1, ap1, p1, tc1, 5);
    scb(2, "w8s1",  iv2, ir2, ov2, or2, a2, b2, ap2, p2, tc2, 1);
  end

  // Single operation on inst 0 with hand-computed result and latency check.
  task automatic one(input string nm, input logic [7:0] x, input logic [7:0] y,
                     input bit apx, input longint unsigned exp);
    int n;
    @(posedge clk); #1;
    iv0 = 1'b1; a0 = x; b0 = y; ap0 = apx; or0 = 1'b1;
    @(negedge clk);
    chk({nm, " in_ready"}, ir0, 1);
    @(posedge clk); #1;
    iv0 = 1'b0;
    n = 1;
    while (!ov0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, n, 3);
    chk({nm, " p"}, p0, exp);
  endtask

  logic [7:0]      sa [4] = '{8'd3, 8'd10, 8'd255, 8'd128};
  logic [7:0]      sb [4] = '{8'd5, 8'd20, 8'd1, 8'd2};
  longint unsigned se [4] = '{64'd15, 64'd200, 64'd255, 64'd256};
  longint unsigned got [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    iv0 = 0; ap0 = 0; or0 = 1; a0 = 0; b0 = 0;
    iv1 = 0; ap1 = 0; or1 = 1; a1 = 0; b1 = 0;
    iv2 = 0; ap2 = 0; or2 = 1; a2 = 0; b2 = 0;

    // Reset with in_valid asserted: must be ignored.
    iv0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", ov0, 0);
    chk("reset p", p0, 0);
    chk("reset txn_count", tc0, 0);
    iv0 = 1'b0;
    rst_n = 1'b1;

    one("exact 255x255", 8'd255, 8'd255, 1'b0, 64'd65025);
    one("exact 0x200",   8'd0,   8'd200, 1'b0, 64'd0);
    one("approx 7x7",    8'd7,   8'd7,   1'b1, 64'd0);
    one("approx 255x255",8'd255, 8'd255, 1'b1, 64'd64976);
    one("approx 8x9",    8'd8,   8'd9,   1'b1, 64'd72);

    // Four-pair stream with a 5-cycle stall on the first result.
    begin
      int idx = 0;
      int stall_left = 0;
      bit started = 1'b0;
      got.delete();
      for (int c = 0; c < 40 && got.size() < 4; c++) begin
        @(posedge clk); #1;
        if (ov0 && !started) begin
          started = 1'b1;
          stall_left = 5;
        end
        or0 = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        iv0 = (idx < 4);
        ap0 = 1'b0;
        if (idx < 4) begin
          a0 = sa[idx];
          b0 = sb[idx];
        end
        @(negedge clk);
        if (!or0) begin
          chk("stall p", p0, 15);
          chk("stall in_ready", ir0, 0);
        end
        if (iv0 && ir0) idx++;
        if (ov0 && or0) got.push_back(p0);
      end
      @(posedge clk); #1;
      iv0 = 1'b0; or0 = 1'b1;
      chk("stream count", got.size(), 4);
      for (int i = 0; i < got.size() && i < 4; i++)
        chk($sformatf("stream out%0d", i), got[i], se[i]);
    end

    // Reset with three operations in flight.
    @(posedge clk); #1;
    iv0 = 1'b1; a0 = 8'd1; b0 = 8'd2; or0 = 1'b1;
    @(posedge clk); #1;
    a0 = 8'd3; b0 = 8'd4;
    @(posedge clk); #1;
    a0 = 8'd5; b0 = 8'd6;
    @(posedge clk); #1;
    rst_n = 1'b0; a0 = 8'd9; b0 = 8'd9;
    @(posedge clk); #1;
    rst_n = 1'b1; iv0 = 1'b0;
    chk("midreset out_valid", ov0, 0);
    chk("midreset p", p0, 0);
    chk("midreset txn_count", tc0, 0);
    one("post-reset 12x12", 8'd12, 8'd12, 1'b0, 64'd144);

    fork
      begin
        int hs = 0;
        for (int c = 0; c < 40000 && hs < 10000; c++) begin
          @(posedge clk); #1;
          iv1 = ($urandom % 4) != 0;
          a1  = 16'($urandom);
          b1  = 16'($urandom);
          ap1 = 1'($urandom);
          or1 = ($urandom % 4) != 0;
          @(negedge clk);
          if (iv1 && ir1) hs++;
        end
        @(posedge clk); #1;
        iv1 = 1'b0; or1 = 1'b1;
        chk("w16s5 handshakes", hs, 10000);
      end
      begin
        int hs = 0;
        for (int c = 0; c < 40000 && hs < 10000; c++) begin
          @(posedge clk); #1;
          iv2 = ($urandom % 4) != 0;
          a2  = 8'($urandom);
          b2  = 8'($urandom);
          ap2 = 1'($urandom);
          or2 = ($urandom % 4) != 0;
          @(negedge clk);
          if (iv2 && ir2) hs++;
        end
        @(posedge clk); #1;
        iv2 = 1'b0; or2 = 1'b1;
        chk("w8s1 handshakes", hs, 10000);
      end
`ifdef ASYM_PIPE_MULT_STATS_EN
      begin
        @(posedge clk); #1;
        iv0 = 1'b1; or0 = 1'b1; ap0 = 1'b0;
        repeat (65600) begin
          a0 = 8'($urandom);
          b0 = 8'($urandom);
          @(posedge clk); #1;
        end
        iv0 = 1'b0;
        @(negedge clk);
        chk("txn_count saturated", tc0, 65535);
      end
`endif
    join

    // Drain and confirm nothing was lost.
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("w8s3 drained",  sq[0].size(), 0);
    chk("w16s5 drained", sq[1].size(), 0);
    chk("w8s1 drained",  sq[2].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
